// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field layout, constants and divider state type.
package fp_pkg;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned BIAS   = 127;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;
   localparam logic [31:0] NEG_INF = 32'hFF80_0000;

   typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier; exponent 0 is treated as zero (denormals flushed).
module fp_classify
   import fp_pkg::*;
(
   input  logic [31:0]     op,
   output logic            is_zero,
   output logic            is_inf,
   output logic            is_nan,
   output logic [FRAC_W:0] sig
);

   logic [EXP_W-1:0]  exp_f;
   logic [FRAC_W-1:0] frac_f;

   always_comb begin
      exp_f   = op[30:23];
      frac_f  = op[22:0];
      is_zero = (exp_f == '0);
      is_inf  = (exp_f == '1) && (frac_f == '0);
      is_nan  = (exp_f == '1) && (frac_f != '0);
      sig     = {~is_zero, frac_f};
   end

endmodule

// File: rtl/fp_divider.sv
// Sequential single-precision divider, radix-2 restoring, one quotient bit per clock.
// Define FP_DIV_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates.
module fp_divider
   import fp_pkg::*;
#(
   parameter int unsigned QBITS = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   localparam int unsigned CNT_W = $clog2(QBITS + 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        a_q, a_d, b_q, b_d;
   logic [24:0]        rem_q, rem_d;
   logic [QBITS-1:0]   quo_q, quo_d;
   logic [31:0]        result_q, result_d;

   logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
   logic [FRAC_W:0]    sig_a, sig_b;

   logic [24:0]        rem_cur, rem_sel, rem_nxt;
   logic [25:0]        diff;
   logic               q_bit;

   logic               sign;
   logic signed [9:0]  e;
   logic [31:0]        qx;
   logic [22:0]        frac;
   logic [31:0]        pack_res;
`ifdef FP_DIV_ROUND_NEAREST_EN
   logic               round_up;
   logic [24:0]        sum;
`else
   logic               trunc_unused;
`endif

   fp_classify u_cls_a (.op(a_q), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan), .sig(sig_a));
   fp_classify u_cls_b (.op(b_q), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan), .sig(sig_b));

   // The remainder is seeded from the latched dividend on the first DIV cycle.
   always_comb begin
      rem_cur = (cnt_q == CNT_W'(QBITS)) ? {1'b0, sig_a} : rem_q;
      diff    = {1'b0, rem_cur} - {2'b00, sig_b};
      q_bit   = ~diff[25];
      rem_sel = q_bit ? diff[24:0] : rem_cur;
      rem_nxt = {rem_sel[23:0], 1'b0};
   end

   always_comb begin
      sign = a_q[31] ^ b_q[31];
      e    = $signed({2'b00, a_q[30:23]} - {2'b00, b_q[30:23]} + 10'(BIAS));
      qx   = 32'(quo_q) << (32 - QBITS);
      frac = '0;
      if (!qx[31]) begin
         qx = qx << 1;
         e  = e - 10'sd1;
      end
`ifdef FP_DIV_ROUND_NEAREST_EN
      round_up = qx[7] & (qx[6] | (|qx[5:0]) | (|rem_q) | qx[8]);
      sum      = {1'b0, qx[31:8]} + 25'(round_up);
      if (sum[24]) begin
         frac = sum[23:1];
         e    = e + 10'sd1;
      end else begin
         frac = sum[22:0];
      end
`else
      frac         = qx[30:8];
      trunc_unused = ^qx[7:0];
`endif
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
         pack_res = QNAN;
      else if (a_inf || b_zero)
         pack_res = sign ? NEG_INF : POS_INF;
      else if (a_zero || b_inf)
         pack_res = {sign, 31'b0};
      else if (e >= 10'sd255)
         pack_res = sign ? NEG_INF : POS_INF;
      else if (e <= 10'sd0)
         pack_res = {sign, 31'b0};
      else
         pack_res = {sign, e[7:0], frac};
   end

   // Counter reaching 0 costs one idle DIV cycle, keeping latency at QBITS+2.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      result_d = result_q;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               cnt_d   = CNT_W'(QBITS);
               rem_d   = '0;
               quo_d   = '0;
               state_d = DIV;
            end
         end
         DIV: begin
            busy = 1'b1;
            if (cnt_q == '0) begin
               state_d = NORM;
            end else begin
               quo_d = {quo_q[QBITS-2:0], q_bit};
               rem_d = rem_nxt;
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         NORM: begin
            busy     = 1'b1;
            result_d = pack_res;
            state_d  = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: doc/fp_divider.md
Name: fp_divider

Overview:
- Sequential IEEE-754 single-precision divider: result = a / b.
- Inverse-operation companion to the team's combinational single-precision multiplier. Shares its field layout: sign[31], exponent[30:23], fraction[22:0], bias 127.
- Mantissa quotient is produced by a radix-2 restoring iteration, one bit per clock.
- start/done handshake; intended as a multi-cycle unit beside the multiplier in the FP datapath.

Parameters:
- QBITS, 26, number of quotient bits generated: 24 significand bits plus guard and round. Legal range 24..30.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  32  dividend; captured with start.
- b  input  32  divisor; captured with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse; result is valid from this cycle on.
- result  output  32  quotient; holds its value until the next done.

Behaviour:
- Reset (rst high at a clock edge): state goes to IDLE; busy=0, done=0, result=32'h0000_0000. Reset takes effect in any state; an in-flight division is discarded.
- States:
  - IDLE: start=1 latches a and b, loads the counter with QBITS, goes to DIV.
  - DIV: one quotient bit per cycle. rem = rem - divisor if nonnegative, else restore. Counter decrements; leave at 0 for NORM.
  - NORM: normalize, round, pack, resolve special cases; go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Latency is fixed: done is asserted exactly QBITS+2 cycles after the start edge (28 by default). Special-case operands also run the full count.
- start while busy is ignored; no queueing. start in the DONE cycle is ignored. start in the IDLE cycle after DONE is accepted.
- Significand arithmetic:
  - Operands are ma={1,a[22:0]} and mb={1,b[22:0]}. Quotient q lies in (0.5, 2).
  - If q[QBITS-1]=0: shift q left by 1 and decrement the exponent.
  - sticky = OR of the final remainder.
- Exponent: e = a[30:23] - b[30:23] + 127, held as a 10-bit signed value.
  - After normalization, e >= 255 -> signed infinity.
  - e <= 0 -> signed zero. No denormal outputs.
- Sign: a[31]^b[31] in every case, NaN excepted.
- Special cases (exp==0 is treated as zero; denormal inputs are flushed), in priority order:
  1. Either operand is NaN, 0/0, or inf/inf -> 32'h7FC00000.
  2. a is inf, or b is zero -> signed infinity.
  3. a is zero, or b is inf -> signed zero.

Optional Feature:
- Macro FP_DIV_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even using the guard, round and sticky bits. A mantissa carry-out increments the exponent, and the overflow check reapplies after rounding.
- Undefined: truncation (round toward zero), matching the multiplier's behaviour. Guard, round and sticky are discarded.
- Latency is identical in both builds.

Decomposition:
- Shared package fp_pkg holds:
  - Field widths EXP_W=8 and FRAC_W=23, and BIAS=127.
  - Constants QNAN=32'h7FC00000, POS_INF=32'h7F800000, NEG_INF=32'hFF800000.
  - The state enum typedef {IDLE, DIV, NORM, DONE}.
- One natural sub-module: fp_classify. It is combinational: 32-bit operand in; is_zero, is_inf, is_nan and the hidden-bit significand out. It is instantiated twice and is reusable by the multiplier.

Test Plan:
- a=40C00000 (6.0), b=40000000 (2.0), start pulse -> done exactly 28 cycles later, result=40400000 (3.0), busy high throughout.
- a=3F800000, b=40400000 (1/3) -> 3EAAAAAA without the macro, 3EAAAAAB with FP_DIV_ROUND_NEAREST_EN.
- Specials, each on its own run:
  - BF800000 / 00000000 -> FF800000.
  - 00000000 / 00000000 -> 7FC00000.
  - 7F000000 / 00800000 -> 7F800000 (overflow).
  - 00800000 / 7F000000 -> 00000000 (underflow).
- Start 6.0/2.0, then start again at cycles 5 and 27 with 1.0/1.0 -> both ignored, single done, result=40400000. A start in the cycle after done is accepted.
- Assert rst at cycle 10 of a division -> busy=0, done=0, result=00000000 next cycle; no done appears later. A new start after reset completes normally.
- Back-to-back: 40400000/3F000000 (3/0.5) then C1200000/40A00000 (-10/5) -> 40C00000 then C0000000, each after 28 cycles.
